muxinv_cfg_onehot: RTL and testbench
====================================

# muxinv_cfg_onehot

Parametrised N-input inverting routing multiplexer with integrated configuration memory: a successor to the fixed 2- and 3-input one-hot mux-inverter cells. Select bits are shifted in through the configuration chain (`ccff_head` to `ccff_tail`) into a shadow register. They are committed to an active one-hot select register on a load strobe, so routing never glitches while the chain shifts. An optional checker flags illegal (zero-hot or multi-hot) selects and forces a safe output. It sits in routing blocks (CB/SB) of the FPGA fabric, daisy-chained with other configuration flops.

## Interface
- `N_IN`, 4: number of data inputs, legal 2..16; also shadow and active register width.
- `DEFAULT_SEL`, 0: index of the input selected by the active register after reset, 0..N_IN-1.
- `prog_clk` in 1: configuration clock, rising edge; the only clock.
- `pReset` in 1: synchronous, active-high reset, sampled on `prog_clk` rising edge.
- `ccff_head` in 1: serial configuration data in.
- `cfg_shift` in 1: shift enable for the shadow register.
- `cfg_load` in 1: commit strobe, shadow register to active register.
- `in` in N_IN: data inputs.
- `out` out 1: inverted selected input.
- `ccff_tail` out 1: serial configuration data out, equal to shadow[N_IN-1].
- `sel_active` out N_IN: active one-hot select, for observability.
- `sel_err` out 1: sticky illegal-select flag for the last committed value.
- `load_done` out 1: one-cycle pulse following each commit.

## Operation
- Shadow register: when `cfg_shift`=1, shadow <= {shadow[N_IN-2:0], ccff_head}. Otherwise it holds.
- Commit: when `cfg_load`=1, sel_active <= shadow.
  - Simultaneous `cfg_shift`+`cfg_load`: the commit captures the pre-shift shadow value, and the shift also occurs.
- Datapath is combinational from `in` and `sel_active`:
  - Legal one-hot select with bit i set: `out` = ~in[i].
  - Illegal select: behaviour depends on configuration (see Configuration).
- `load_done`: registered copy of `cfg_load`, high for exactly one cycle per load cycle. Back-to-back loads keep it high.
- `ccff_tail` is a flop output, not a combinational path from `ccff_head`. Chained instances therefore shift correctly on a shared `cfg_shift`.
- Reset values, applied one cycle after `pReset`=1 on a clock edge:
  - shadow = 0, so `ccff_tail`=0.
  - `sel_active` = one-hot at `DEFAULT_SEL`.
  - `sel_err` = 0.
  - `load_done` = 0.
- `pReset` has priority over `cfg_shift` and `cfg_load` in the same cycle. A partially shifted word is discarded, and no commit happens.

## Timing
- A full word takes N_IN shift cycles: first bit shifted lands at shadow[N_IN-1] and appears on `ccff_tail` after N_IN shift cycles.
- Commit latency is 1 cycle: `sel_active`, `sel_err` and `load_done` update on the edge that samples `cfg_load`=1.
- `out` follows `in` and `sel_active` with zero cycles of latency (combinational).
- `sel_err` is updated only on commit or reset. Otherwise it holds its value.
- No handshake back-pressure: shift and load are accepted every cycle they are asserted.

## Configuration
- `MUXINV_CFG_ONEHOT_CHECK_EN` defined:
  - On commit, `sel_err` <= (popcount(shadow) != 1).
  - While `sel_err`=1, `out` is forced to 0 regardless of `in`.
- Not defined:
  - No checker logic; `sel_err` is tied 0.
  - Multi-hot select: `out` = ~in[lowest set index].
  - Zero-hot select: `out` = 0.

## Test plan
- Reset: assert `pReset` for 1 cycle with N_IN=4, DEFAULT_SEL=2, `in`=4'b0100 -> `sel_active`=4'b0100, `out`=0, `ccff_tail`=0, `sel_err`=0, `load_done`=0.
- Shift and commit: with N_IN=4, shift serial bits 1,0,0,0 (first to last), then pulse `cfg_load` -> `sel_active`=4'b1000 next cycle, `load_done` high for 1 cycle. Then `in`=4'b0111 -> `out`=1, and `in`=4'b1111 -> `out`=0.
- Glitch-free reconfiguration: during 4 shift cycles with `cfg_load`=0, `sel_active` and `out` stay constant. `ccff_tail` replays the previous shadow bits in order MSB first.
- Simultaneous events: `cfg_shift`=1 and `cfg_load`=1 with shadow=4'b0010 and `ccff_head`=1 -> `sel_active`=4'b0010 and shadow=4'b0101.
- Illegal select with the macro defined: commit shadow=4'b0110 -> `sel_err`=1 and `out`=0 for any `in`. A later commit of 4'b0001 clears `sel_err`. Without the macro, 4'b0110 with `in`=4'b0000 -> `out`=1 (selects index 1), `sel_err`=0.
- Reset mid-operation: after 2 of 4 shift cycles, assert `pReset` together with `cfg_load` -> no commit, `sel_active`=DEFAULT_SEL one-hot, shadow=0, `load_done`=0.

Source files
------------

// File: rtl/muxinv_cfg_onehot_if.sv
// Configuration-chain and datapath bundle for muxinv_cfg_onehot.
// master = configuration/data driver, slave = the mux cell.
interface muxinv_cfg_onehot_if #(
    parameter int N_IN = 4
);
    logic            ccff_head;
    logic            cfg_shift;
    logic            cfg_load;
    logic [N_IN-1:0] in;
    logic            out;
    logic            ccff_tail;
    logic [N_IN-1:0] sel_active;
    logic            sel_err;
    logic            load_done;

    modport master (
        output ccff_head,
        output cfg_shift,
        output cfg_load,
        output in,
        input  out,
        input  ccff_tail,
        input  sel_active,
        input  sel_err,
        input  load_done
    );

    modport slave (
        input  ccff_head,
        input  cfg_shift,
        input  cfg_load,
        input  in,
        output out,
        output ccff_tail,
        output sel_active,
        output sel_err,
        output load_done
    );
endinterface

// File: rtl/muxinv_cfg_onehot.sv
// N-input inverting mux with shadow/active one-hot config registers.
// Define MUXINV_CFG_ONEHOT_CHECK_EN to enable the illegal-select checker.
module muxinv_cfg_onehot #(
    parameter int N_IN        = 4,
    parameter int DEFAULT_SEL = 0
) (
    input logic                 prog_clk,
    input logic                 pReset,
    muxinv_cfg_onehot_if.slave  bus
);

    localparam logic [N_IN-1:0] RST_SEL =
        {{(N_IN-1){1'b0}}, 1'b1} << DEFAULT_SEL;

    if (N_IN < 2 || N_IN > 16) begin : g_bad_n
        $error("N_IN must be 2..16");
    end
    if (DEFAULT_SEL < 0 || DEFAULT_SEL >= N_IN) begin : g_bad_sel
        $error("DEFAULT_SEL out of range");
    end

    logic [N_IN-1:0] shadow_q;
    logic [N_IN-1:0] active_q;
    logic            load_done_q;
    logic            pick;

    // Commit reads the pre-shift shadow, so shift and load can coincide.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shadow_q    <= '0;
            active_q    <= RST_SEL;
            load_done_q <= 1'b0;
        end else begin
            if (bus.cfg_shift) begin
                shadow_q <= {shadow_q[N_IN-2:0], bus.ccff_head};
            end
            if (bus.cfg_load) begin
                active_q <= shadow_q;
            end
            load_done_q <= bus.cfg_load;
        end
    end

    // Lowest set index wins; zero-hot leaves pick at 0.
    always_comb begin
        pick = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (active_q[i]) begin
                pick = ~bus.in[i];
            end
        end
    end

`ifdef MUXINV_CFG_ONEHOT_CHECK_EN
    logic sel_err_q;
    logic shadow_bad;

    always_comb begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < N_IN; i++) begin
            cnt += int'(shadow_q[i]);
        end
        shadow_bad = (cnt != 1);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sel_err_q <= 1'b0;
        end else if (bus.cfg_load) begin
            sel_err_q <= shadow_bad;
        end
    end

    assign bus.out     = sel_err_q ? 1'b0 : pick;
    assign bus.sel_err = sel_err_q;
`else
    assign bus.out     = pick;
    assign bus.sel_err = 1'b0;
`endif

    assign bus.ccff_tail  = shadow_q[N_IN-1];
    assign bus.sel_active = active_q;
    assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_muxinv_cfg_onehot.sv
// Directed bench for muxinv_cfg_onehot, N_IN=4, DEFAULT_SEL=2.
// Expected values follow the checker macro when it is defined.
module tb_muxinv_cfg_onehot;

    localparam int N    = 4;
    localparam int DSEL = 2;
`ifdef MUXINV_CFG_ONEHOT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0] sel;
        logic [3:0] din;
        logic       exp_out;
        logic       exp_err;
    } vec_t;

    logic prog_clk = 1'b0;
    logic pReset;
    int   checks = 0;
    int   errors = 0;

    muxinv_cfg_onehot_if #(.N_IN(N)) bus ();

    muxinv_cfg_onehot #(
        .N_IN       (N),
        .DEFAULT_SEL(DSEL)
    ) dut (
        .prog_clk(prog_clk),
        .pReset  (pReset),
        .bus     (bus)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_word(input logic [3:0] w);
        bus.cfg_shift = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            bus.ccff_head = w[k];
            step();
        end
        bus.cfg_shift = 1'b0;
    endtask

    vec_t       vt[11];
    logic [3:0] prev_sel;
    logic [3:0] prev_act;
    logic       prev_out;
    logic [7:0] combo;

    initial begin
        vt[0]  = '{4'b1000, 4'b0111, 1'b1, 1'b0};
        vt[1]  = '{4'b1000, 4'b1111, 1'b0, 1'b0};
        vt[2]  = '{4'b0001, 4'b1110, 1'b1, 1'b0};
        vt[3]  = '{4'b0001, 4'b0001, 1'b0, 1'b0};
        vt[4]  = '{4'b0100, 4'b1011, 1'b1, 1'b0};
        vt[5]  = '{4'b0010, 4'b0010, 1'b0, 1'b0};
        vt[6]  = '{4'b0110, 4'b0000, CHK ? 1'b0 : 1'b1, CHK};
        vt[7]  = '{4'b0110, 4'b0100, CHK ? 1'b0 : 1'b1, CHK};
        vt[8]  = '{4'b0000, 4'b1111, 1'b0, CHK};
        vt[9]  = '{4'b0001, 4'b0000, 1'b1, 1'b0};
        vt[10] = '{4'b1100, 4'b0100, 1'b0, CHK};

        pReset        = 1'b1;
        bus.ccff_head = 1'b0;
        bus.cfg_shift = 1'b0;
        bus.cfg_load  = 1'b0;
        bus.in        = 4'b0100;
        step();
        chk("rst_sel", 32'(bus.sel_active), 32'h4);
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_tail", 32'(bus.ccff_tail), 32'h0);
        chk("rst_err", 32'(bus.sel_err), 32'h0);
        chk("rst_ld", 32'(bus.load_done), 32'h0);
        pReset = 1'b0;

        prev_sel = 4'b0000;
        prev_act = 4'b0100;
        prev_out = 1'b0;
        for (int i = 0; i < 11; i++) begin
            combo = {prev_sel, vt[i].sel};
            chk("tail0", 32'(bus.ccff_tail), 32'(combo[7]));
            bus.cfg_shift = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                bus.ccff_head = vt[i].sel[4-k];
                step();
                chk("tail_k", 32'(bus.ccff_tail), 32'(combo[7-k]));
                chk("hold_sel", 32'(bus.sel_active), 32'(prev_act));
                chk("hold_out", 32'(bus.out), 32'(prev_out));
            end
            bus.cfg_shift = 1'b0;
            bus.cfg_load  = 1'b1;
            step();
            chk("v_sel", 32'(bus.sel_active), 32'(vt[i].sel));
            chk("v_ld1", 32'(bus.load_done), 32'h1);
            chk("v_err", 32'(bus.sel_err), 32'(vt[i].exp_err));
            bus.cfg_load = 1'b0;
            bus.in       = vt[i].din;
            step();
            chk("v_ld0", 32'(bus.load_done), 32'h0);
            chk("v_out", 32'(bus.out), 32'(vt[i].exp_out));
            prev_sel = vt[i].sel;
            prev_act = vt[i].sel;
            prev_out = vt[i].exp_out;
        end

        // Shift and load together: commit sees the pre-shift shadow.
        shift_word(4'b0010);
        bus.cfg_shift = 1'b1;
        bus.cfg_load  = 1'b1;
        bus.ccff_head = 1'b1;
        step();
        chk("sim_sel", 32'(bus.sel_active), 32'h2);
        chk("sim_ld", 32'(bus.load_done), 32'h1);
        chk("sim_err", 32'(bus.sel_err), 32'h0);
        bus.cfg_shift = 1'b0;
        step();
        chk("b2b_sel", 32'(bus.sel_active), 32'h5);
        chk("b2b_ld", 32'(bus.load_done), 32'h1);
        chk("b2b_err", 32'(bus.sel_err), 32'(CHK));
        bus.cfg_load = 1'b0;
        step();
        chk("b2b_ld0", 32'(bus.load_done), 32'h0);

        // Reset mid-shift with a coincident load.
        shift_word(4'b0001);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        chk("pre_sel", 32'(bus.sel_active), 32'h1);
        bus.cfg_shift = 1'b1;
        bus.ccff_head = 1'b1;
        step();
        step();
        pReset       = 1'b1;
        bus.cfg_load = 1'b1;
        step();
        chk("mr_sel", 32'(bus.sel_active), 32'h4);
        chk("mr_ld", 32'(bus.load_done), 32'h0);
        chk("mr_tail", 32'(bus.ccff_tail), 32'h0);
        chk("mr_err", 32'(bus.sel_err), 32'h0);
        pReset        = 1'b0;
        bus.cfg_shift = 1'b0;
        bus.in        = 4'b1111;
        step();
        chk("mr_zero", 32'(bus.sel_active), 32'h0);
        chk("mr_zerr", 32'(bus.sel_err), 32'(CHK));
        chk("mr_zout", 32'(bus.out), 32'h0);
        bus.cfg_load = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
